// File: rtl/agdc_pkg.sv
// Shared types for the multi-door garage door controller.
// Holds the per-door state encoding and the Moore output decode.
package agdc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        MV_UP = 2'b01,
        MV_DN = 2'b10,
        FAULT = 2'b11
    } agdc_state_e;

    // Returns {up_m, dn_m, fault} for a state.
    function automatic logic [2:0] agdc_outs(agdc_state_e s);
        logic [2:0] o;
        o = 3'b000;
        unique case (s)
            MV_UP: o = 3'b100;
            MV_DN: o = 3'b010;
            FAULT: o = 3'b001;
            IDLE:  o = 3'b000;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/agdc_door_fsm.sv
// One door: Moore FSM with auto-reverse, travel watchdog, latched fault.
// Ports: clk, rst_n (async low), limit/activate/obst/clr_fault in;
//        up_m, dn_m, fault out (registered state decode only).
module agdc_door_fsm
    import agdc_pkg::*;
#(
    parameter int TIMEOUT_W   = 8,
    parameter int TIMEOUT_CYC = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic activate,
    input  logic up_max,
    input  logic dn_max,
    input  logic obst,
    input  logic clr_fault,
    output logic up_m,
    output logic dn_m,
    output logic fault
);

    localparam logic [TIMEOUT_W-1:0] TMO_LAST =
        TIMEOUT_W'(TIMEOUT_CYC - 1);

    agdc_state_e          state;
    agdc_state_e          state_nx;
    logic [TIMEOUT_W-1:0] cnt;
    logic                 both;
    logic                 tmo;
    logic                 moving;

    assign both   = up_max & dn_max;
    assign tmo    = (cnt == TMO_LAST);
    assign moving = (state == MV_UP) || (state == MV_DN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            // Any transition (incl. auto-reverse) restarts the count.
            if (state_nx != state || !moving)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (both)
                    state_nx = FAULT;
                else if (activate && up_max)
                    state_nx = obst ? IDLE : MV_DN;
                else if (activate)
                    state_nx = MV_UP;
            end
            MV_UP: begin
                if (both)
                    state_nx = FAULT;
                else if (up_max)
                    state_nx = IDLE;
                else if (tmo)
                    state_nx = FAULT;
            end
            MV_DN: begin
                if (both)
                    state_nx = FAULT;
                else if (dn_max)
                    state_nx = IDLE;
                else if (obst)
                    state_nx = MV_UP;
                else if (tmo)
                    state_nx = FAULT;
            end
            FAULT: begin
                if (clr_fault && !both)
                    state_nx = IDLE;
            end
        endcase
    end

    assign {up_m, dn_m, fault} = agdc_outs(state);

endmodule

// File: rtl/agdc_multi_ctrl.sv
// N independent garage door channels, one agdc_door_fsm per door.
// Ports: CLK, RST (async low), per-door bit buses in and out.
module agdc_multi_ctrl
    import agdc_pkg::*;
#(
    parameter int N_DOORS     = 2,
    parameter int TIMEOUT_W   = 8,
    parameter int TIMEOUT_CYC = 200
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N_DOORS-1:0] Activate,
    input  logic [N_DOORS-1:0] UP_Max,
    input  logic [N_DOORS-1:0] DN_Max,
    input  logic [N_DOORS-1:0] Obst,
    input  logic [N_DOORS-1:0] Clr_Fault,
    output logic [N_DOORS-1:0] UP_M,
    output logic [N_DOORS-1:0] DN_M,
    output logic [N_DOORS-1:0] Fault
);

    for (genvar i = 0; i < N_DOORS; i++) begin : g_door
        agdc_door_fsm #(
            .TIMEOUT_W   (TIMEOUT_W),
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_door (
            .clk       (CLK),
            .rst_n     (RST),
            .activate  (Activate[i]),
            .up_max    (UP_Max[i]),
            .dn_max    (DN_Max[i]),
            .obst      (Obst[i]),
            .clr_fault (Clr_Fault[i]),
            .up_m      (UP_M[i]),
            .dn_m      (DN_M[i]),
            .fault     (Fault[i])
        );
    end

endmodule

// File: tb/tb_agdc_multi_ctrl.sv
// Directed bench for agdc_multi_ctrl, two doors, 16-cycle watchdog.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_agdc_multi_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] Activate, UP_Max, DN_Max, Obst, Clr_Fault;
    logic [1:0] UP_M, DN_M, Fault;

    int n_cmp = 0;
    int n_bad = 0;

    agdc_multi_ctrl #(
        .N_DOORS     (2),
        .TIMEOUT_W   (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Activate  (Activate),
        .UP_Max    (UP_Max),
        .DN_Max    (DN_Max),
        .Obst      (Obst),
        .Clr_Fault (Clr_Fault),
        .UP_M      (UP_M),
        .DN_M      (DN_M),
        .Fault     (Fault)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    task automatic chk3(input string tag,
                        input logic [1:0] up,
                        input logic [1:0] dn,
                        input logic [1:0] ft);
        chk({tag, ".up"}, {6'd0, UP_M}, {6'd0, up});
        chk({tag, ".dn"}, {6'd0, DN_M}, {6'd0, dn});
        chk({tag, ".ft"}, {6'd0, Fault}, {6'd0, ft});
    endtask

    task automatic clr_in();
        Activate  = '0;
        UP_Max    = '0;
        DN_Max    = '0;
        Obst      = '0;
        Clr_Fault = '0;
    endtask

    initial begin
        RST = 1'b0;
        clr_in();
        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            Activate  = 2'($urandom);
            UP_Max    = 2'($urandom);
            DN_Max    = 2'($urandom);
            Obst      = 2'($urandom);
            Clr_Fault = 2'($urandom);
            @(posedge CLK);
            #1;
            chk3("rst", 2'b00, 2'b00, 2'b00);
        end
        @(negedge CLK);
        clr_in();
        RST = 1'b1;
        tick();
        chk3("idle", 2'b00, 2'b00, 2'b00);

        // Close/open on door 0
        Activate = 2'b01;
        UP_Max   = 2'b01;
        tick();
        chk3("close", 2'b00, 2'b01, 2'b00);
        UP_Max = 2'b00;
        tick(2);
        chk3("closing", 2'b00, 2'b01, 2'b00);
        DN_Max = 2'b01;
        tick();
        chk3("closed", 2'b00, 2'b00, 2'b00);
        tick();
        chk3("reopen", 2'b01, 2'b00, 2'b00);
        Activate = 2'b00;
        DN_Max   = 2'b00;
        UP_Max   = 2'b01;
        tick();
        chk3("opened", 2'b00, 2'b00, 2'b00);

        // Auto-reverse on door 1
        Activate = 2'b10;
        UP_Max   = 2'b10;
        tick();
        chk3("d1close", 2'b00, 2'b10, 2'b00);
        Activate = 2'b00;
        UP_Max   = 2'b00;
        tick(3);
        Obst = 2'b10;
        tick();
        Obst = 2'b00;
        chk3("reverse", 2'b10, 2'b00, 2'b00);
        tick(15);
        chk3("rev15", 2'b10, 2'b00, 2'b00);
        tick();
        chk3("rev16", 2'b00, 2'b00, 2'b10);
        Clr_Fault = 2'b10;
        tick();
        Clr_Fault = 2'b00;
        chk3("d1clr", 2'b00, 2'b00, 2'b00);

        // Watchdog on door 0
        Activate = 2'b01;
        tick();
        chk3("up", 2'b01, 2'b00, 2'b00);
        tick(15);
        chk3("up15", 2'b01, 2'b00, 2'b00);
        tick();
        chk3("tmo", 2'b00, 2'b00, 2'b01);
        tick(2);
        chk3("hold", 2'b00, 2'b00, 2'b01);
        Activate  = 2'b00;
        Clr_Fault = 2'b01;
        tick();
        Clr_Fault = 2'b00;
        chk3("clr0", 2'b00, 2'b00, 2'b00);

        // Both limits
        Activate = 2'b01;
        tick();
        chk3("up2", 2'b01, 2'b00, 2'b00);
        Activate = 2'b00;
        UP_Max   = 2'b11;
        DN_Max   = 2'b11;
        tick();
        chk3("both", 2'b00, 2'b00, 2'b11);
        Clr_Fault = 2'b11;
        tick();
        chk3("bothclr", 2'b00, 2'b00, 2'b11);
        DN_Max = 2'b00;
        tick();
        Clr_Fault = 2'b00;
        chk3("bothok", 2'b00, 2'b00, 2'b00);

        // Limit arrives on the timeout cycle
        UP_Max   = 2'b00;
        Activate = 2'b01;
        tick();
        Activate = 2'b00;
        chk3("up3", 2'b01, 2'b00, 2'b00);
        tick(15);
        UP_Max = 2'b01;
        tick();
        chk3("limtmo", 2'b00, 2'b00, 2'b00);

        // Async reset during MV_DN
        Activate = 2'b01;
        tick();
        Activate = 2'b00;
        UP_Max   = 2'b00;
        chk3("dn4", 2'b00, 2'b01, 2'b00);
        #1 RST = 1'b0;
        #1;
        chk3("arst", 2'b00, 2'b00, 2'b00);
        @(negedge CLK);
        RST = 1'b1;
        tick();
        chk3("post", 2'b00, 2'b00, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/agdc_multi_ctrl.md
# agdc_multi_ctrl

Multi-door automatic garage door controller: N independent Moore state machines, one per door, each driving an up/down motor pair from limit-switch and activate inputs. Each door also has obstruction auto-reverse, a travel-timeout watchdog and a latched fault state. Sits between the debounced door sensor inputs and the motor driver stage; it supersedes the single-door Moore controller.

## Interface
- N_DOORS, 2: number of independent door channels (1..8).
- TIMEOUT_W, 8: width of the per-door travel counter.
- TIMEOUT_CYC, 200: maximum cycles in a motion state before fault; must be < 2^TIMEOUT_W and ≥ 2.

- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- Activate  in  N_DOORS  per-door activate request, level-sensitive.
- UP_Max  in  N_DOORS  per-door upper limit switch (door fully open).
- DN_Max  in  N_DOORS  per-door lower limit switch (door fully closed).
- Obst  in  N_DOORS  per-door obstruction sensor, active-high.
- Clr_Fault  in  N_DOORS  per-door fault clear, level.
- UP_M  out  N_DOORS  motor up command.
- DN_M  out  N_DOORS  motor down command.
- Fault  out  N_DOORS  door in FAULT state.

## Operation
- States per door: IDLE, MV_UP, MV_DN, FAULT. Outputs are pure Moore decodes: MV_UP → UP_M=1; MV_DN → DN_M=1; FAULT → Fault=1; all others 0. UP_M and DN_M are never both 1.
- "Both limits" means UP_Max & DN_Max. It is a sensor inconsistency and takes top priority in every state except FAULT.
- IDLE, in priority order:
  - both limits → FAULT.
  - Activate & UP_Max & !Obst → MV_DN.
  - Activate & UP_Max & Obst → stay IDLE (closing inhibited).
  - Activate & DN_Max → MV_UP.
  - Activate with neither limit (door mid-travel) → MV_UP.
  - Otherwise stay.
- MV_UP, in priority order: both limits → FAULT; UP_Max → IDLE; timeout → FAULT; else stay. Obst is ignored.
- MV_DN, in priority order: both limits → FAULT; DN_Max → IDLE; Obst → MV_UP (auto-reverse); timeout → FAULT; else stay.
- FAULT: Clr_Fault & !both limits → IDLE; otherwise stay. Activate is ignored.
- Travel counter:
  - Per door, TIMEOUT_W bits.
  - Cleared on every state transition and whenever the door is in IDLE or FAULT.
  - Increments each cycle spent in MV_UP/MV_DN.
  - Timeout is true when count == TIMEOUT_CYC-1. The counter never wraps.
- Limit reached in the same cycle as timeout: the limit wins and the door returns to IDLE.
- Auto-reverse restarts the counter at 0.
- Activate is level-sensitive. If Activate is still held when a door reaches a limit, the door leaves IDLE one cycle later in the opposite direction. This is intended.
- Channels are fully independent; there is no shared arbitration.

## Timing
- Reset (RST=0, asynchronous): every door goes to IDLE, counters to 0, UP_M=DN_M=Fault=0 immediately, without waiting for a clock edge. Reset deassertion is synchronised externally.
- Reset asserted mid-motion stops the motor output asynchronously.
- Inputs are sampled on the rising CLK edge. Outputs reflect the new state one edge after the causing input (latency 1 cycle). There is no combinational input-to-output path.
- Timeout: after entering MV_UP/MV_DN at edge k with no limit or Obst, the door enters FAULT at edge k+TIMEOUT_CYC.
- Clr_Fault held high in FAULT: the door moves to IDLE at the next edge. It may then start on the following edge if Activate is set.

## Structure
- Package agdc_pkg holds:
  - the state enum (IDLE=2'b00, MV_UP=2'b01, MV_DN=2'b10, FAULT=2'b11);
  - a function decoding state to {UP_M, DN_M, Fault}.
- Sub-module agdc_door_fsm contains one door's FSM plus its travel counter, parameterised by TIMEOUT_W/TIMEOUT_CYC.
- Top agdc_multi_ctrl instantiates N_DOORS copies in a generate loop and slices the buses.

## Test plan
All scenarios use N_DOORS=2 and TIMEOUT_CYC=16.
- Reset: hold RST=0 with random inputs. Required: UP_M=DN_M=Fault=2'b00. Assert RST=0 again mid-MV_DN: DN_M drops before the next edge.
- Close/open cycle on door 0:
  - Activate=01, UP_Max=01 → DN_M=01 after 1 edge.
  - DN_Max=01 → next edge DN_M=00.
  - UP_Max=00, Activate still held → next edge UP_M=01.
  - Door 1 outputs stay 0 throughout.
- Auto-reverse: door 1 in MV_DN, pulse Obst=10 for one cycle → next edge UP_M=10, DN_M=00. Counter restarts, so no fault within 15 further cycles.
- Timeout: door 0 in MV_UP with no limit for 16 cycles → Fault=01, UP_M=00. Activate held in FAULT keeps the door in FAULT. Clr_Fault=01 → next edge Fault=00 (IDLE).
- Both limits: UP_Max=DN_Max=11 while door 0 is in MV_UP and door 1 is in IDLE → Fault=11 after 1 edge. Clr_Fault=11 while both limits are still high → stay in FAULT. Drop DN_Max, then Clr_Fault → IDLE.
- Limit and timeout coincide: UP_Max rises on cycle 15 of MV_UP → IDLE, Fault stays 0.
